seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
Controller that sequences a bit-serial Moore pattern matcher over a stream of parallel words. It accepts words through a valid/ready handshake and shifts each one MSB-first, one bit per clock, into a programmable-length pattern matcher. It counts matches, in overlapping or non-overlapping mode, and reports completion with a start/busy/done handshake. It sits between a word-oriented producer and the serial sequence-detection datapath, and owns its configuration and scheduling.

Parameters:
WORD_W, 8, width of input word; bits consumed MSB-first
PAT_MAX, 4, maximum pattern length in bits (>=2)
CNT_W, 8, width of saturating match counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a scan; honoured only in IDLE
cfg_pattern  input  PAT_MAX  pattern; bit [len-1] is the earliest bit in time, bit [0] the latest
cfg_len  input  clog2(PAT_MAX+1)  pattern length; legal range 1..PAT_MAX
cfg_overlap  input  1  1 = overlapping matches; 0 = history cleared after each match
word_valid  input  1  producer has a word
word_data  input  WORD_W  word to scan
word_last  input  1  marks the final word of the scan; qualified by the handshake
word_ready  output  1  controller accepts a word this cycle
busy  output  1  scan in progress (all states except IDLE)
match  output  1  registered one-cycle pulse per detected match
match_count  output  CNT_W  saturating number of matches in the current/last scan
done  output  1  one-cycle pulse at scan end
err  output  1  one-cycle pulse when start is rejected for illegal cfg_len

Behaviour:
- Reset (async): state IDLE. word_ready, busy, match, done and err are 0. match_count is 0. History, bits_seen and latched config are cleared. Reset takes effect mid-operation with no completion pulse.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE, start=1, cfg_len in 1..PAT_MAX:
  - latch cfg_pattern, cfg_len and cfg_overlap (config is ignored thereafter until the next start)
  - clear match_count, history and bits_seen
  - go to LOAD next cycle
- IDLE, start=1, illegal cfg_len (0 or >PAT_MAX): err=1 for the next cycle; stay IDLE; match_count unchanged.
- start outside IDLE is ignored.
- LOAD:
  - word_ready=1 (combinational from state only)
  - on word_valid&&word_ready: capture word_data and word_last, set bit index to WORD_W-1, go to SHIFT
  - without valid: stay in LOAD indefinitely; history is preserved
- SHIFT: exactly WORD_W cycles; word_ready=0. Each cycle, for b = word[idx]:
  - hist <= {hist[PAT_MAX-2:0], b}
  - bits_seen <= min(bits_seen+1, PAT_MAX)
  - hit = (bits_seen+1 >= len) && (new hist[len-1:0] == pattern[len-1:0])
  - on hit: match <= 1 next cycle, else 0; match_count increments and holds at 2^CNT_W-1
  - on hit with cfg_overlap=0: bits_seen <= 0 (hit bit not reused)
- Leaving SHIFT after the idx=0 cycle: go to DONE if the captured last flag is set, else to LOAD.
- History and bits_seen persist across word boundaries; the stream is continuous.
- Latency:
  - handshake in cycle k; bit WORD_W-1 processed in cycle k+1; bit 0 in cycle k+WORD_W
  - match pulse and count update visible one cycle after the completing bit
  - the final bit's match therefore coincides with the first DONE or LOAD cycle
- DONE: done=1 for one cycle; go to IDLE. match_count includes the final bit's match and holds until the next accepted start.
- busy=1 in LOAD, SHIFT and DONE.

Test Plan:
- Overlap, len=2, pattern 2'b11, WORD_W=8, single word 8'b0111_0110 with last=1:
  - match pulses after stream bits 3, 4 and 7; match_count=3 at done
  - done occurs 1 cycle after the 8th SHIFT cycle; word_ready=1 only in the LOAD cycle
- Same stimulus with cfg_overlap=0: matches after bits 3 and 7 only; match_count=2.
- Cross-word, len=3, pattern 3'b101:
  - send 8'h01 (last=0), hold word_valid low 5 cycles (word_ready stays 1, no match), then send 8'h40 (last=1)
  - exactly one match, after stream bit 10; match_count=1
- Illegal config and busy start:
  - start with cfg_len=0: err=1 for one cycle; busy=0 and word_ready=0 throughout
  - start with cfg_len=PAT_MAX+1: same response
  - start pulsed during SHIFT: no effect on state or count
- Saturation, CNT_W=2, len=1, pattern 1'b1, word 8'hFF with last=1: match pulses on 8 consecutive cycles; match_count stops at 3.
- Reset mid-SHIFT, after 4 bits:
  - all outputs 0 asynchronously, before the next edge; no done pulse
  - a following legal start with word 8'h03 and pattern 2'b11 (len=2) yields match_count=1

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// Word-fed scan controller: shifts each accepted word MSB-first into a
// programmable-length Moore pattern matcher and counts matches per scan.
module seq_scan_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 4,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [PAT_MAX-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_MAX+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           word_valid,
  input  logic [WORD_W-1:0]              word_data,
  input  logic                           word_last,
  output logic                           word_ready,
  output logic                           busy,
  output logic                           match,
  output logic [CNT_W-1:0]               match_count,
  output logic                           done,
  output logic                           err
);

  localparam int LEN_W = $clog2(PAT_MAX + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state;
  logic [PAT_MAX-1:0] pat;
  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] new_hist;
  logic [PAT_MAX-1:0] mask;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   bits_seen;
  logic [LEN_W-1:0]   seen_sat;
  logic [LEN_W:0]     seen_inc;
  logic               overlap;
  logic [WORD_W-1:0]  word;
  logic               last;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic               cfg_ok;

  assign word_ready = (state == LOAD);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // Only the low len bits of the history take part in the comparison.
  always_comb begin
    cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
    new_hist = {hist[PAT_MAX-2:0], word[idx]};
    seen_inc = {1'b0, bits_seen} + (LEN_W+1)'(1);
    seen_sat = (seen_inc > (LEN_W+1)'(PAT_MAX)) ? LEN_W'(PAT_MAX) : seen_inc[LEN_W-1:0];
    mask     = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    hit = (seen_inc >= {1'b0, len}) && ((new_hist & mask) == (pat & mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pat         <= '0;
      len         <= '0;
      overlap     <= 1'b0;
      hist        <= '0;
      bits_seen   <= '0;
      word        <= '0;
      last        <= 1'b0;
      idx         <= '0;
      match       <= 1'b0;
      match_count <= '0;
      err         <= 1'b0;
    end else begin
      match <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              pat         <= cfg_pattern;
              len         <= cfg_len;
              overlap     <= cfg_overlap;
              match_count <= '0;
              hist        <= '0;
              bits_seen   <= '0;
              state       <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_valid) begin
            word  <= word_data;
            last  <= word_last;
            idx   <= IDX_W'(WORD_W - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          hist <= new_hist;
          if (hit) begin
            match <= 1'b1;
            if (match_count != '1) begin
              match_count <= match_count + CNT_W'(1);
            end
            // Non-overlapping mode forgets the bits that formed this match.
            bits_seen <= overlap ? seen_sat : '0;
          end else begin
            bits_seen <= seen_sat;
          end
          if (idx == '0) begin
            state <= last ? DONE : LOAD;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: a stream-level reference model queues
// expected match positions/counts; a negedge monitor checks what the DUT shows.
module tb_seq_scan_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_MAX = 4;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(PAT_MAX + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [PAT_MAX-1:0]  cfg_pattern = '0;
  logic [LEN_W-1:0]    cfg_len = '0;
  logic                cfg_overlap = 1'b0;
  logic                word_valid = 1'b0;
  logic [WORD_W-1:0]   word_data = '0;
  logic                word_last = 1'b0;
  logic                word_ready;
  logic                busy;
  logic                match;
  logic [CNT_W-1:0]    match_count;
  logic                done;
  logic                err;

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .busy(busy), .match(match),
    .match_count(match_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int pos; int cnt;} exp_t;
  exp_t              match_q[$];
  int                done_q[$];
  logic [WORD_W-1:0] stim_words[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = -1;
  int hs_word = 0;
  int word_index = 0;
  int last_hs = -1;
  int done_seen = 0;
  int last_count = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: match events are resolved against the handshake that preceded
  // them, before a coincident new handshake is recorded.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hs_cyc = -1;
      word_index = 0;
      last_hs = -1;
    end else begin
      if (match) begin
        if (match_q.size() == 0) begin
          failNow("unexpected_match");
        end else begin
          exp_t e;
          e = match_q.pop_front();
          checkOutput("match_pos", hs_word * WORD_W + (cyc - hs_cyc - 2), e.pos);
          checkOutput("match_count", int'(match_count), e.cnt);
        end
      end
      if (hs_cyc >= 0 && cyc - hs_cyc >= 1 && cyc - hs_cyc <= WORD_W) begin
        checkOutput("ready_low_in_shift", int'(word_ready), 0);
        checkOutput("busy_in_shift", int'(busy), 1);
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          failNow("unexpected_done");
        end else begin
          checkOutput("done_count", int'(match_count), done_q.pop_front());
          checkOutput("done_timing", cyc, last_hs + WORD_W + 1);
        end
      end
      if (word_valid && word_ready) begin
        hs_word = word_index;
        hs_cyc = cyc;
        word_index++;
        if (word_last) last_hs = cyc;
      end
      if (start && !busy) word_index = 0;
    end
  end

  // Reference model: walk the bit stream, a match is the last len bits equal
  // to the pattern with at least len bits since the last clear.
  task automatic modelScan(input logic [PAT_MAX-1:0] pat, input int len, input bit ovl);
    bit s[$];
    int since = 0;
    int cnt = 0;
    for (int w = 0; w < stim_words.size(); w++) begin
      for (int i = WORD_W - 1; i >= 0; i--) begin
        bit ok;
        s.push_back(stim_words[w][i]);
        since++;
        if (since >= len) begin
          ok = 1'b1;
          for (int k = 0; k < len; k++) begin
            if (s[s.size() - 1 - k] != pat[k]) ok = 1'b0;
          end
          if (ok) begin
            if (cnt < CNT_MAX) cnt++;
            match_q.push_back('{s.size() - 1, cnt});
            if (!ovl) since = 0;
          end
        end
      end
    end
    done_q.push_back(cnt);
    last_count = cnt;
  endtask

  task automatic doStart(input logic [PAT_MAX-1:0] pat, input int len, input bit ovl);
    cfg_pattern = pat;
    cfg_len = LEN_W'(len);
    cfg_overlap = ovl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_pattern = PAT_MAX'($urandom);
    cfg_len = LEN_W'($urandom);
    cfg_overlap = 1'($urandom);
  endtask

  task automatic sendWord(input logic [WORD_W-1:0] data, input bit last, input int gap, input bit check_stall);
    int guard;
    if (gap > 0) begin
      guard = 0;
      @(negedge clk);
      while (!word_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      repeat (gap) begin
        if (check_stall) begin
          checkOutput("stall_ready", int'(word_ready), 1);
          checkOutput("stall_match", int'(match), 0);
        end
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    word_data = data;
    word_last = last;
    word_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!word_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) failNow("ready_timeout");
    @(posedge clk); #1;
    word_valid = 1'b0;
    word_data = WORD_W'($urandom);
    word_last = 1'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      cfg_len = LEN_W'($urandom_range(1, PAT_MAX));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // One complete scan of stim_words; gap < 0 selects random producer stalls.
  task automatic applyStimulus(input logic [PAT_MAX-1:0] pat, input int len, input bit ovl, input int gap);
    int tgt;
    int guard;
    tgt = done_seen + 1;
    modelScan(pat, len, ovl);
    doStart(pat, len, ovl);
    for (int w = 0; w < stim_words.size(); w++) begin
      sendWord(stim_words[w], w == stim_words.size() - 1,
               (gap < 0) ? $urandom_range(0, 2) : gap, gap >= 0);
    end
    guard = 0;
    while (done_seen < tgt && guard < 4 * WORD_W) begin
      @(negedge clk);
      guard++;
    end
    if (done_seen < tgt) failNow("done_timeout");
    @(posedge clk); #1;
    checkOutput("match_q_empty", match_q.size(), 0);
    checkOutput("done_q_empty", done_q.size(), 0);
    match_q.delete();
    done_q.delete();
  endtask

  task automatic illegalStart(input int len);
    cfg_len = LEN_W'(len);
    start = 1'b1;
    @(negedge clk);
    checkOutput("err_before_edge", int'(err), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("err_pulse", int'(err), 1);
    checkOutput("err_busy", int'(busy), 0);
    checkOutput("err_ready", int'(word_ready), 0);
    checkOutput("err_count_kept", int'(match_count), last_count);
    @(negedge clk);
    checkOutput("err_one_cycle", int'(err), 0);
    checkOutput("err_still_idle", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    checkOutput("reset_ready", int'(word_ready), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_match", int'(match), 0);
    checkOutput("reset_count", int'(match_count), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_err", int'(err), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] overlap and non-overlap on 0x76");
    stim_words = '{8'h76};
    applyStimulus(4'b0011, 2, 1'b1, 0);
    checkOutput("overlap_final", int'(match_count), 3);
    applyStimulus(4'b0011, 2, 1'b0, 0);
    checkOutput("nonoverlap_final", int'(match_count), 2);

    $display("[TB] cross-word match with producer stall");
    stim_words = '{8'h01, 8'h40};
    applyStimulus(4'b0101, 3, 1'b1, 5);
    checkOutput("crossword_final", int'(match_count), 1);

    $display("[TB] illegal lengths");
    illegalStart(0);
    illegalStart(PAT_MAX + 1);
    illegalStart((1 << LEN_W) - 1);

    $display("[TB] counter saturation");
    stim_words.delete();
    for (int w = 0; w < 33; w++) stim_words.push_back(8'hFF);
    applyStimulus(4'b0001, 1, 1'b1, -1);
    checkOutput("saturated_final", int'(match_count), CNT_MAX);

    $display("[TB] randomized scans");
    for (int t = 0; t < 40; t++) begin
      int nw;
      nw = $urandom_range(1, 5);
      stim_words.delete();
      for (int w = 0; w < nw; w++) stim_words.push_back(WORD_W'($urandom));
      applyStimulus(PAT_MAX'($urandom), $urandom_range(1, PAT_MAX), 1'($urandom), -1);
    end

    $display("[TB] reset during shift");
    doStart(4'b0011, 2, 1'b1);
    sendWord(8'h00, 1'b1, 0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_ready", int'(word_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_match", int'(match), 0);
    checkOutput("rst_count", int'(match_count), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    match_q.delete();
    done_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    stim_words = '{8'h03};
    applyStimulus(4'b0011, 2, 1'b1, 0);
    checkOutput("after_reset_final", int'(match_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
